// File: rtl/fir_filter_bank.sv
// rtl/fir_filter_bank.sv - time-multiplexed multi-channel FIR filter bank
// One shared MAC engine walks all taps of a single channel per accepted sample.
module fir_filter_bank #(
  parameter int N_CH   = 2,
  parameter int N_TAPS = 16,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter int TAP_W  = $clog2(N_TAPS),
  parameter int OUT_W  = DATA_W + COEF_W + TAP_W
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [CH_W-1:0]       in_ch,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  input  logic                  coef_we,
  input  logic [TAP_W-1:0]      coef_addr,
  input  logic [COEF_W-1:0]     coef_data,
  output logic                  out_valid,
  output logic [CH_W-1:0]       out_ch,
  output logic [OUT_W-1:0]      out_data,
  output logic [N_CH*OUT_W-1:0] out_all
);
  localparam int PROD_W = DATA_W + COEF_W;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
  state_t state;

  logic [DATA_W-1:0]        dline [N_CH][N_TAPS];
  logic signed [COEF_W-1:0] coef  [N_TAPS];
  logic [CH_W-1:0]          ch;
  logic [TAP_W-1:0]         idx;
  logic signed [OUT_W-1:0]  acc;

  logic signed [DATA_W:0]   x_ext;
  logic signed [PROD_W-1:0] x_w;
  logic signed [PROD_W-1:0] c_w;
  logic signed [PROD_W-1:0] prod;
  logic                     accept;
  logic                     coef_ok;

  // Samples are unsigned ADC codes: zero-extend before the signed multiply.
  always_comb begin
    x_ext = signed'({1'b0, dline[ch][idx]});
    x_w   = PROD_W'(x_ext);
    c_w   = PROD_W'(coef[idx]);
    prod  = x_w * c_w;
  end

  assign accept  = (state == IDLE) && in_valid && (32'(in_ch) < N_CH);
  assign coef_ok = (state == IDLE) && coef_we && (32'(coef_addr) < N_TAPS);

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      out_all   <= '0;
      ch        <= '0;
      idx       <= '0;
      acc       <= '0;
      for (int t = 0; t < N_TAPS; t++) begin
        coef[t] <= COEF_W'(1);
        for (int c = 0; c < N_CH; c++) dline[c][t] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      // Lands on the accept edge too, so the MAC sees the new value.
      if (coef_ok) coef[coef_addr] <= coef_data;
      case (state)
        IDLE: begin
          if (accept) begin
            for (int c = 0; c < N_CH; c++) begin
              if (in_ch == CH_W'(c)) begin
                dline[c][0] <= in_data;
                for (int t = 1; t < N_TAPS; t++) dline[c][t] <= dline[c][t-1];
              end
            end
            ch       <= in_ch;
            idx      <= '0;
            acc      <= '0;
            in_ready <= 1'b0;
            state    <= MAC;
          end
        end
        MAC: begin
          acc <= acc + OUT_W'(prod);
          idx <= idx + TAP_W'(1);
          if (32'(idx) == N_TAPS - 1) state <= DONE;
        end
        DONE: begin
          out_data  <= acc;
          out_ch    <= ch;
          out_valid <= 1'b1;
          in_ready  <= 1'b1;
          for (int k = 0; k < N_CH; k++) begin
            if (ch == CH_W'(k)) out_all[k*OUT_W +: OUT_W] <= acc;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_filter_bank.sv
// tb/tb_fir_filter_bank.sv - directed self-checking bench for fir_filter_bank
// Drives a default 2-channel build and a 3-channel build from one clock and reset.
module tb_fir_filter_bank;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic rst_n;

  logic        in_valid, in_ready, coef_we, out_valid;
  logic [0:0]  in_ch, out_ch;
  logic [7:0]  in_data, coef_data;
  logic [3:0]  coef_addr;
  logic [19:0] out_data;
  logic [39:0] out_all;

  logic        in_valid3, in_ready3, coef_we3, out_valid3;
  logic [1:0]  in_ch3, out_ch3;
  logic [7:0]  in_data3, coef_data3;
  logic [3:0]  coef_addr3;
  logic [19:0] out_data3;
  logic [59:0] out_all3;

  int checks = 0;
  int passed = 0;

  fir_filter_bank dut (
    .CLK(CLK), .rst_n(rst_n), .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
    .in_ready(in_ready), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data), .out_all(out_all)
  );

  fir_filter_bank #(.N_CH(3)) dut3 (
    .CLK(CLK), .rst_n(rst_n), .in_valid(in_valid3), .in_ch(in_ch3), .in_data(in_data3),
    .in_ready(in_ready3), .coef_we(coef_we3), .coef_addr(coef_addr3), .coef_data(coef_data3),
    .out_valid(out_valid3), .out_ch(out_ch3), .out_data(out_data3), .out_all(out_all3)
  );

  task automatic wait_result(output bit got, output logic signed [19:0] res, output int lat);
    got = 0; lat = 0;
    while (!got && lat < 40) begin
      if (out_valid === 1'b1) got = 1;
      else begin @(posedge CLK); #1; lat++; end
    end
    res = out_data;
  endtask

  task automatic run_sample(input int ch, input int data, output bit got,
                            output logic signed [19:0] res, output int lat);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(posedge CLK); #1; n++; end
    in_valid = 1; in_ch = 1'(ch); in_data = 8'(data);
    @(posedge CLK); #1;
    in_valid = 0;
    wait_result(got, res, lat);
  endtask

  task automatic run3(input int ch, input int data, output bit got, output logic signed [19:0] res);
    int lat = 0;
    in_valid3 = 1; in_ch3 = 2'(ch); in_data3 = 8'(data);
    @(posedge CLK); #1;
    in_valid3 = 0;
    got = 0;
    while (!got && lat < 40) begin
      if (out_valid3 === 1'b1) got = 1;
      else begin @(posedge CLK); #1; lat++; end
    end
    res = out_data3;
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%0d exp=1", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0d exp=0", out_valid); else passed++;
    checks++; if (out_ch !== 1'b0) $display("FAIL reset_out_ch got=%0d exp=0", out_ch); else passed++;
    checks++; if (out_data !== 20'd0) $display("FAIL reset_out_data got=%0d exp=0", out_data); else passed++;
    checks++; if (out_all !== 40'd0) $display("FAIL reset_out_all got=%0h exp=0", out_all); else passed++;
    checks++; if (in_ready3 !== 1'b1) $display("FAIL reset3_in_ready got=%0d exp=1", in_ready3); else passed++;
    checks++; if (out_all3 !== 60'd0) $display("FAIL reset3_out_all got=%0h exp=0", out_all3); else passed++;
  endtask

  task automatic test_moving_sum();
    bit got; logic signed [19:0] res; int lat;
    for (int k = 1; k <= 16; k++) begin
      run_sample(0, 255, got, res, lat);
      checks++; if (!got || res !== 20'(255 * k)) $display("FAIL moving_sum[%0d] got=%0d exp=%0d", k, res, 255 * k); else passed++;
      checks++; if (out_ch !== 1'b0) $display("FAIL moving_sum_ch[%0d] got=%0d exp=0", k, out_ch); else passed++;
      if (k == 1) begin
        checks++; if (lat != 17) $display("FAIL moving_sum_latency got=%0d exp=17", lat); else passed++;
      end
    end
    checks++; if (out_all[39:20] !== 20'd0) $display("FAIL moving_sum_ch1_slot got=%0d exp=0", out_all[39:20]); else passed++;
    checks++; if (out_all[19:0] !== 20'd4080) $display("FAIL moving_sum_ch0_slot got=%0d exp=4080", out_all[19:0]); else passed++;
  endtask

  task automatic test_handshake();
    int nlow = 0, npulse = 0, first_lat = -100, second_lat = -1;
    logic signed [19:0] r1 = '0, r2 = '0;
    in_valid = 1; in_ch = 0; in_data = 8'd10;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (cyc == 5) begin coef_we = 1; coef_addr = 4'd15; coef_data = 8'd100; end
      else coef_we = 0;
      @(posedge CLK); #1;
      if (cyc == 0) in_data = 8'd20;
      if (cyc == first_lat + 1) in_valid = 0;
      if (npulse == 0 && in_ready === 1'b0) nlow++;
      if (out_valid === 1'b1) begin
        npulse++;
        if (npulse == 1) begin first_lat = cyc; r1 = out_data; end
        else begin second_lat = cyc; r2 = out_data; end
      end
    end
    in_valid = 0; coef_we = 0;
    checks++; if (nlow != 17) $display("FAIL hs_ready_low_cycles got=%0d exp=17", nlow); else passed++;
    checks++; if (first_lat != 17) $display("FAIL hs_first_latency got=%0d exp=17", first_lat); else passed++;
    checks++; if (r1 !== 20'sd3835) $display("FAIL hs_first_result got=%0d exp=3835", r1); else passed++;
    checks++; if (npulse != 2) $display("FAIL hs_pulse_count got=%0d exp=2", npulse); else passed++;
    checks++; if (second_lat != 35) $display("FAIL hs_second_latency got=%0d exp=35", second_lat); else passed++;
    checks++; if (r2 !== 20'sd3600) $display("FAIL hs_busy_coef_ignored got=%0d exp=3600", r2); else passed++;
  endtask

  task automatic test_impulse();
    bit got; logic signed [19:0] res; int lat;
    for (int i = 0; i < 16; i++) begin
      coef_we = 1; coef_addr = 4'(i); coef_data = 8'(i - 8);
      @(posedge CLK); #1;
    end
    coef_we = 0;
    for (int k = 0; k < 16; k++) begin
      run_sample(1, (k == 0) ? 1 : 0, got, res, lat);
      checks++; if (!got || res !== 20'(k - 8)) $display("FAIL impulse[%0d] got=%0d exp=%0d", k, res, k - 8); else passed++;
    end
    checks++; if (out_ch !== 1'b1) $display("FAIL impulse_ch got=%0d exp=1", out_ch); else passed++;
    checks++; if (out_all[19:0] !== 20'd3600) $display("FAIL impulse_ch0_slot got=%0d exp=3600", out_all[19:0]); else passed++;
    checks++; if (out_all[39:20] !== 20'd7) $display("FAIL impulse_ch1_slot got=%0d exp=7", out_all[39:20]); else passed++;
    coef_we = 1; coef_addr = 4'd0; coef_data = 8'd5;
    in_valid = 1; in_ch = 1; in_data = 8'd2;
    @(posedge CLK); #1;
    coef_we = 0; in_valid = 0;
    wait_result(got, res, lat);
    checks++; if (!got || res !== 20'sd10) $display("FAIL same_edge_coef got=%0d exp=10", res); else passed++;
  endtask

  task automatic test_negative();
    bit got; logic signed [19:0] res; int lat;
    for (int i = 0; i < 16; i++) begin
      coef_we = 1; coef_addr = 4'(i); coef_data = 8'h80;
      @(posedge CLK); #1;
    end
    coef_we = 0;
    for (int k = 0; k < 16; k++) run_sample(0, 255, got, res, lat);
    checks++; if (!got || res !== 20'(-522240)) $display("FAIL negative_extreme got=%0d exp=-522240", res); else passed++;
    checks++; if (out_all[19:0] !== 20'(-522240)) $display("FAIL negative_slot got=%0h exp=80800", out_all[19:0]); else passed++;
  endtask

  task automatic test_reset_mid_mac();
    bit got, seen = 0; logic signed [19:0] res; int lat;
    in_valid = 1; in_ch = 0; in_data = 8'd9;
    @(posedge CLK); #1;
    in_valid = 0;
    repeat (4) begin @(posedge CLK); #1; end
    rst_n = 0;
    @(posedge CLK); #1;
    rst_n = 1;
    checks++; if (in_ready !== 1'b1) $display("FAIL rst_mid_in_ready got=%0d exp=1", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_mid_out_valid got=%0d exp=0", out_valid); else passed++;
    checks++; if (out_data !== 20'd0) $display("FAIL rst_mid_out_data got=%0d exp=0", out_data); else passed++;
    checks++; if (out_all !== 40'd0) $display("FAIL rst_mid_out_all got=%0h exp=0", out_all); else passed++;
    repeat (20) begin @(posedge CLK); #1; if (out_valid === 1'b1) seen = 1; end
    checks++; if (seen) $display("FAIL rst_mid_no_result got=1 exp=0"); else passed++;
    run_sample(0, 7, got, res, lat);
    checks++; if (!got || res !== 20'sd7) $display("FAIL rst_mid_ch0_after got=%0d exp=7", res); else passed++;
    run_sample(1, 7, got, res, lat);
    checks++; if (!got || res !== 20'sd7) $display("FAIL rst_mid_ch1_after got=%0d exp=7", res); else passed++;
  endtask

  task automatic test_n_ch3();
    bit got, seen = 0; logic signed [19:0] res;
    int chs [6] = '{0, 2, 0, 2, 0, 2};
    int dat [6] = '{1, 10, 2, 20, 3, 30};
    int exp [6] = '{1, 10, 3, 30, 6, 60};
    in_valid3 = 1; in_ch3 = 2'd3; in_data3 = 8'd50;
    @(posedge CLK); #1;
    in_valid3 = 0;
    checks++; if (in_ready3 !== 1'b1) $display("FAIL ch3_oob_ready got=%0d exp=1", in_ready3); else passed++;
    repeat (25) begin @(posedge CLK); #1; if (out_valid3 === 1'b1) seen = 1; end
    checks++; if (seen) $display("FAIL ch3_oob_no_output got=1 exp=0"); else passed++;
    for (int k = 0; k < 6; k++) begin
      run3(chs[k], dat[k], got, res);
      checks++; if (!got || res !== 20'(exp[k]) || out_ch3 !== 2'(chs[k]))
        $display("FAIL ch3_interleave[%0d] got=%0d ch=%0d exp=%0d ch=%0d", k, res, out_ch3, exp[k], chs[k]);
      else passed++;
    end
    checks++; if (out_all3[19:0] !== 20'd6) $display("FAIL ch3_slot0 got=%0d exp=6", out_all3[19:0]); else passed++;
    checks++; if (out_all3[39:20] !== 20'd0) $display("FAIL ch3_slot1 got=%0d exp=0", out_all3[39:20]); else passed++;
    checks++; if (out_all3[59:40] !== 20'd60) $display("FAIL ch3_slot2 got=%0d exp=60", out_all3[59:40]); else passed++;
  endtask

  initial begin
    rst_n = 0;
    in_valid = 0; in_ch = 0; in_data = 0; coef_we = 0; coef_addr = 0; coef_data = 0;
    in_valid3 = 0; in_ch3 = 0; in_data3 = 0; coef_we3 = 0; coef_addr3 = 0; coef_data3 = 0;
    repeat (3) @(posedge CLK);
    #1;
    rst_n = 1;
    test_reset();
    test_moving_sum();
    test_handshake();
    test_impulse();
    test_negative();
    test_reset_mid_mac();
    test_n_ch3();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/fir_filter_bank.md
# fir_filter_bank

Parametrised, time-multiplexed FIR filter bank: one shared multiply-accumulate engine serves `N_CH` independent sample channels, each with its own delay line. It also provides a run-time loadable coefficient set. It sits between the controller's per-LED ADC sample outputs and the filtered-output ports. It generalises the fixed two-channel, fixed-coefficient filter pair to any channel count, tap count and width.

## Interface
Parameters:
- `N_CH`, 2, number of channels (≥1); `CH_W` = max(1, clog2(N_CH)).
- `N_TAPS`, 16, taps per channel (≥2); `TAP_W` = clog2(N_TAPS).
- `DATA_W`, 8, input sample width, unsigned.
- `COEF_W`, 8, coefficient width, signed two's complement.
- `OUT_W`, `DATA_W+COEF_W+TAP_W` (20 by default), output width, signed.

Ports:
- `CLK`, in, 1: the single clock. One clock domain; all logic on the rising edge.
- `rst_n`, in, 1: reset, synchronous and active-low.
- `in_valid`, in, 1: a sample is offered.
- `in_ch`, in, `CH_W`: channel index of the offered sample.
- `in_data`, in, `DATA_W`: sample value (unsigned ADC code).
- `in_ready`, out, 1: engine idle. A sample is accepted on an edge where `in_valid` and `in_ready` are both 1.
- `coef_we`, in, 1: coefficient write strobe.
- `coef_addr`, in, `TAP_W`: tap index to write.
- `coef_data`, in, `COEF_W`: coefficient value.
- `out_valid`, out, 1: one-cycle pulse when a new result is available.
- `out_ch`, out, `CH_W`: channel of the current result.
- `out_data`, out, `OUT_W`: most recent result.
- `out_all`, out, `N_CH*OUT_W`: latest result per channel. Channel k occupies bits [k*OUT_W +: OUT_W].

## Operation
- y[ch] = Σ_{i=0..N_TAPS-1} c[i]·x_ch[i].
  - x_ch[0] is the newest accepted sample of that channel.
  - The coefficient set c is shared by all channels.
- Arithmetic is full precision and never saturates:
  - the input is zero-extended to signed;
  - each product is `DATA_W+COEF_W` bits signed;
  - the accumulator is `OUT_W` bits signed.
- FSM states and transitions:
  - IDLE: `in_ready`=1. On accept, shift `in_data` into the delay line of `in_ch` (oldest sample dropped), latch the channel, set acc=0 and idx=0, then go to MAC.
  - MAC: each cycle, acc += c[idx]·x_ch[idx] and idx++. After the term for idx=N_TAPS-1 is added, go to DONE.
  - DONE: write acc to `out_data` and to the `out_all` slot of the channel; set `out_ch`; pulse `out_valid`; go to IDLE.
- Out-of-range channel: `in_valid` with `in_ch` ≥ `N_CH` while idle is dropped. No state change, no output.
- Delay lines of other channels are never disturbed.
- Coefficient writes:
  - A write is honoured only when `in_ready`=1; `coef_we` is ignored while busy.
  - `coef_addr` ≥ `N_TAPS` is ignored.
  - A write and a sample accept may occur on the same edge. The write lands on that edge, so the MAC already uses the new coefficient.
- Reset state (whenever `rst_n`=0 at an edge, including mid-MAC):
  - FSM returns to IDLE; any result in flight is discarded.
  - All delay lines are cleared to 0.
  - All coefficients are set to 1, so the default filter is an N_TAPS-point moving sum.
  - Output reset values: `in_ready`=1 from the first cycle after reset, `out_valid`=0, `out_ch`=0, `out_data`=0, `out_all`=0.

## Timing
- Accept edge E0 is followed by MAC edges E1..E_N_TAPS and the DONE edge E_(N_TAPS+1).
- `out_valid` is high for exactly the one cycle after E_(N_TAPS+1). `out_data`, `out_ch` and `out_all` update on that same edge and hold until the next result.
- `in_ready` is 0 from the cycle after E0 through E_(N_TAPS+1), and 1 again in the cycle in which `out_valid`=1. A new sample can be accepted on the edge that ends the `out_valid` cycle.
- Maximum throughput is one sample every N_TAPS+2 cycles, across all channels combined.
- A sample held with `in_valid` high while busy is accepted exactly once, at the first idle edge. The source holds `in_ch`/`in_data` stable until then.

## Test plan
- Defaults (N_CH=2, N_TAPS=16, all coefficients 1): 16 samples of 255 on ch0.
  - Outputs are 255, 510, …, 4080, each with `out_ch`=0.
  - `out_all` ch1 slot stays 0.
- Impulse response: load c[i]=i−8 for i=0..15, then on ch1 send 1 followed by 15 zeros.
  - Successive `out_data` values are −8, −7, …, 7.
  - The ch0 slot is unchanged.
- Negative extreme: all coefficients −128, 16 samples of 255.
  - Final `out_data` = −522240, no wrap.
- Handshake: hold `in_valid` high with a sample.
  - It is accepted once; `out_valid` pulses 17 edges after accept.
  - `in_ready`=0 for 17 cycles.
  - `coef_we` issued mid-MAC has no effect (readback via the impulse test).
- Reset mid-MAC (assert `rst_n`=0 for one edge at E5).
  - No `out_valid`; all outputs are 0; `in_ready`=1.
  - Coefficients are back to 1: a following sample of 7 gives 7.
- N_CH=3 build: a sample with `in_ch`=3 produces no output and no delay-line change. Interleaved ch0/ch2 streams produce independent moving sums.
